// File: rtl/riscv_lsu_bridge.sv
// Load/store bridge from the multicycle RISC-V core data port to a valid/ready bus.
// Optional build macro MISALIGN_SPLIT_EN: word-crossing accesses run as two bus beats.
module riscv_lsu_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_req,
   input  logic                  core_we,
   input  logic [ADDR_WIDTH-1:0] core_adr,
   input  logic [31:0]           core_wdata,
   input  logic [2:0]            core_funct3,
   output logic [31:0]           core_rdata,
   output logic                  core_done,
   output logic                  core_busy,
   output logic                  core_fault,
   output logic [1:0]            core_fault_cause,
   output logic                  bus_valid,
   input  logic                  bus_ready,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_adr,
   output logic [3:0]            bus_be,
   output logic [31:0]           bus_wdata,
   input  logic [31:0]           bus_rdata,
   input  logic                  bus_err
);

   localparam int unsigned CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit          TO_EN   = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;
   state_t state, state_d;

   logic [ADDR_WIDTH-1:0] adr_q;
   logic                  we_q;
   logic [31:0]           wdata_q;
   logic [2:0]            f3_q;
   logic [CW-1:0]         cnt;

   logic                  in_illegal, in_misal;
   logic [1:0]            off;
   logic [3:0]            mask;
   logic [ADDR_WIDTH-1:0] base, beat_adr;
   logic [3:0]            beat_be;
   logic [31:0]           beat_wdata, rsel, ext;
   logic                  split, accept, timeout_hit;
   logic                  done_d, fault_d, load_d;
   logic [1:0]            cause_d;

   assign off  = adr_q[1:0];
   assign base = {adr_q[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      in_illegal = (core_funct3 == 3'b011) || (core_funct3[2:1] == 2'b11) ||
                   (core_funct3[2] && core_we);
`ifdef MISALIGN_SPLIT_EN
      in_misal = 1'b0;
`else
      in_misal = ((core_funct3[1:0] == 2'b01) && core_adr[0]) ||
                 ((core_funct3[1:0] == 2'b10) && (core_adr[1:0] != 2'b00));
`endif
      case (f3_q[1:0])
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
   end

`ifdef MISALIGN_SPLIT_EN
   logic [31:0] rdata1_q;
   logic [7:0]  be8;
   logic [63:0] w64, r64;
   logic        in_b2;

   // Lane mask and data span two words; the upper half belongs to beat 2.
   assign in_b2      = (state == BEAT2);
   assign be8        = {4'b0000, mask} << off;
   assign w64        = {32'h0, wdata_q} << {off, 3'b000};
   assign split      = |be8[7:4];
   assign beat_be    = in_b2 ? be8[7:4] : be8[3:0];
   assign beat_wdata = in_b2 ? w64[63:32] : w64[31:0];
   assign beat_adr   = base + (in_b2 ? ADDR_WIDTH'(4) : '0);
   assign r64        = in_b2 ? {bus_rdata, rdata1_q} : {32'h0, bus_rdata};
   assign rsel       = 32'(r64 >> {off, 3'b000});

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdata1_q <= '0;
      else if (state == BEAT1 && accept)
         rdata1_q <= bus_rdata;
   end
`else
   assign split      = 1'b0;
   assign beat_be    = mask << off;
   assign beat_wdata = wdata_q << {off, 3'b000};
   assign beat_adr   = base;
   assign rsel       = bus_rdata >> {off, 3'b000};
`endif

   always_comb begin
      case (f3_q[1:0])
         2'b00:   ext = {{24{~f3_q[2] & rsel[7]}}, rsel[7:0]};
         2'b01:   ext = {{16{~f3_q[2] & rsel[15]}}, rsel[15:0]};
         default: ext = rsel;
      endcase
   end

   assign bus_valid = (state == BEAT1) || (state == BEAT2);
   assign bus_we    = bus_valid & we_q;
   assign bus_adr   = bus_valid ? beat_adr : '0;
   assign bus_be    = bus_valid ? beat_be : '0;
   assign bus_wdata = bus_valid ? beat_wdata : '0;
   assign core_busy = (state != IDLE);

   assign accept      = bus_valid && bus_ready;
   assign timeout_hit = TO_EN && bus_valid && !bus_ready && (cnt == TO_LAST);

   always_comb begin
      state_d = state;
      fault_d = 1'b0;
      cause_d = 2'b00;
      load_d  = 1'b0;
      case (state)
         IDLE: begin
            if (core_req) begin
               if (in_illegal || in_misal) begin
                  state_d = DONE;
                  fault_d = 1'b1;
                  cause_d = 2'b01;
               end else begin
                  state_d = BEAT1;
               end
            end
         end
         BEAT1, BEAT2: begin
            if (accept) begin
               if (bus_err) begin
                  state_d = DONE;
                  fault_d = 1'b1;
                  cause_d = 2'b11;
               end else if (state == BEAT1 && split) begin
                  state_d = BEAT2;
               end else begin
                  state_d = DONE;
                  load_d  = !we_q;
               end
            end else if (timeout_hit) begin
               state_d = DONE;
               fault_d = 1'b1;
               cause_d = 2'b10;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         adr_q            <= '0;
         we_q             <= 1'b0;
         wdata_q          <= '0;
         f3_q             <= '0;
         cnt              <= '0;
         core_rdata       <= '0;
         core_done        <= 1'b0;
         core_fault       <= 1'b0;
         core_fault_cause <= 2'b00;
      end else begin
         state            <= state_d;
         core_done        <= done_d;
         core_fault       <= fault_d;
         core_fault_cause <= cause_d;
         if (state == IDLE && core_req) begin
            adr_q   <= core_adr;
            we_q    <= core_we;
            wdata_q <= core_wdata;
            f3_q    <= core_funct3;
         end
         if (load_d)
            core_rdata <= ext;
         // Wait counter restarts whenever the beat changes or completes.
         cnt <= (bus_valid && !bus_ready && state_d == state) ? cnt + CW'(1) : '0;
      end
   end

endmodule

// File: tb/tb_riscv_lsu_bridge.sv
// Randomised self-checking bench for riscv_lsu_bridge against a per-access behavioural model.
module tb_riscv_lsu_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_adr = '0, core_wdata = '0;
   logic [2:0]  core_funct3 = '0;
   logic [31:0] core_rdata;
   logic        core_done, core_busy, core_fault;
   logic [1:0]  core_fault_cause;
   logic        bus_valid, bus_we;
   logic        bus_ready = 1'b0, bus_err = 1'b0;
   logic [31:0] bus_adr, bus_wdata;
   logic [31:0] bus_rdata = '0;
   logic [3:0]  bus_be;

   always #5 clk = ~clk;

   riscv_lsu_bridge #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_adr(core_adr),
      .core_wdata(core_wdata), .core_funct3(core_funct3),
      .core_rdata(core_rdata), .core_done(core_done), .core_busy(core_busy),
      .core_fault(core_fault), .core_fault_cause(core_fault_cause),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_adr(bus_adr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;

   logic        exp_valid, exp_busy, exp_done, exp_fault, exp_we;
   logic [1:0]  exp_cause;
   logic [31:0] exp_adr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;

   logic [31:0] seen_adr1, seen_adr2, seen_wd1;
   logic [3:0]  seen_be1, seen_be2;
   logic [1:0]  seen_cause;
   bit          seen_any_valid;
   int          lat;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", core_busy, exp_busy);
         chk("done", core_done, exp_done);
         chk("fault", core_fault, exp_fault);
         chk("cause", core_fault_cause, exp_cause);
         chk("rdata", core_rdata, exp_rdata);
         chk("valid", bus_valid, exp_valid);
         if (exp_valid) begin
            chk("bus_adr", bus_adr, exp_adr);
            chk("bus_be", bus_be, exp_be);
            chk("bus_we", bus_we, exp_we);
            chk("bus_wdata", bus_wdata, exp_wdata);
         end
      end
   end

   function automatic int sz_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [1:0] fault_of(input bit we, input logic [31:0] adr, input logic [2:0] f3);
      if (f3[1:0] == 2'd3 || f3 == 3'd6 || (f3[2] && we)) return 2'd1;
      if (!SPLIT && (adr % 32'(sz_of(f3))) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] r1, input logic [31:0] r2);
      int sz;
      logic [63:0] r, m;
      sz = sz_of(f3);
      r  = {r2, r1} >> (8 * off);
      m  = (64'd1 << (8 * sz)) - 64'd1;
      r  = r & m;
      if (!f3[2] && r[8*sz-1]) r = r | ~m;
      return r[31:0];
   endfunction

   task automatic set_idle();
      exp_valid = 0; exp_busy = 0; exp_done = 0; exp_fault = 0; exp_cause = 0;
   endtask

   task automatic drive_junk();
      core_req    = 1'($urandom);
      core_we     = 1'($urandom);
      core_adr    = $urandom;
      core_wdata  = $urandom;
      core_funct3 = 3'($urandom);
   endtask

   // Runs one access starting in an IDLE cycle; returns cycles from request edge to done.
   task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [2:0] f3, input int w1, input int w2,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input bit e1, input bit e2, output int l);
      logic [1:0]  cause, off;
      logic [7:0]  be8;
      logic [63:0] w64;
      int          sz, nb, w;
      bit          e, acc;
      sz    = sz_of(f3);
      off   = adr[1:0];
      cause = fault_of(we, adr, f3);
      be8   = 8'(((1 << sz) - 1) << off);
      w64   = {32'h0, wd} << (8 * off);
      nb    = (be8[7:4] != 0) ? 2 : 1;
      seen_any_valid = 0;
      seen_adr1 = '0; seen_adr2 = '0; seen_be1 = '0; seen_be2 = '0; seen_wd1 = '0;
      set_idle();
      core_req = 1; core_we = we; core_adr = adr; core_wdata = wd; core_funct3 = f3;
      bus_ready = 0;
      @(posedge clk); #1;
      l = 1;
      if (cause == 0) begin
         for (int b = 0; b < nb && cause == 0; b++) begin
            w = (b == 0) ? w1 : w2;
            e = (b == 0) ? e1 : e2;
            for (int k = 0; k < 64; k++) begin
               drive_junk();
               exp_valid = 1; exp_busy = 1; exp_done = 0; exp_fault = 0; exp_cause = 0;
               exp_adr   = (adr & ~32'h3) + 32'(4 * b);
               exp_be    = 4'(be8 >> (4 * b));
               exp_we    = we;
               exp_wdata = 32'(w64 >> (32 * b));
               if (bus_valid) seen_any_valid = 1;
               if (k == 0 && b == 0) begin
                  seen_adr1 = bus_adr; seen_be1 = bus_be; seen_wd1 = bus_wdata;
               end
               if (k == 0 && b == 1) begin
                  seen_adr2 = bus_adr; seen_be2 = bus_be;
               end
               acc       = (w < TO) && (k == w);
               bus_ready = acc;
               bus_rdata = acc ? ((b == 0) ? rd1 : rd2) : $urandom;
               bus_err   = acc ? e : 1'($urandom);
               @(posedge clk); #1;
               l++;
               if (acc) begin
                  if (e) cause = 2'd3;
                  break;
               end
               if (k == TO - 1) begin
                  cause = 2'd2;
                  break;
               end
            end
         end
         bus_ready = 0;
         bus_err   = 0;
      end
      drive_junk();
      if (cause == 0 && !we) exp_rdata = ld_val(f3, off, rd1, rd2);
      exp_valid = 0; exp_busy = 1; exp_done = 1; exp_fault = (cause != 0); exp_cause = cause;
      seen_cause = core_fault_cause;
      if (bus_valid) seen_any_valid = 1;
      @(posedge clk); #1;
      core_req = 0;
      set_idle();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rdata"}, core_rdata, 0);
      chk({tag, "_done"}, core_done, 0);
      chk({tag, "_busy"}, core_busy, 0);
      chk({tag, "_fault"}, core_fault, 0);
      chk({tag, "_cause"}, core_fault_cause, 0);
      chk({tag, "_valid"}, bus_valid, 0);
      chk({tag, "_we"}, bus_we, 0);
      chk({tag, "_adr"}, bus_adr, 0);
      chk({tag, "_be"}, bus_be, 0);
      chk({tag, "_wdata"}, bus_wdata, 0);
   endtask

   initial begin
      logic [2:0] f3;
      int sel, w1, w2;
      logic [31:0] adr;
      exp_rdata = '0; exp_adr = '0; exp_be = '0; exp_we = 0; exp_wdata = '0;
      set_idle();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 0;
      chk_en = 1;
      @(posedge clk); #1;

      do_txn(0, 32'h100, 0, 3'b010, 0, 0, 32'hDEADBEEF, 0, 0, 0, lat);
      chk("lw_lat", lat, 2);
      chk("lw_be", seen_be1, 4'b1111);
      chk("lw_adr", seen_adr1, 32'h100);
      chk("lw_rdata", core_rdata, 32'hDEADBEEF);
      do_txn(0, 32'h103, 0, 3'b000, 0, 0, 32'h80123456, 0, 0, 0, lat);
      chk("lb_rdata", core_rdata, 32'hFFFFFF80);
      do_txn(0, 32'h103, 0, 3'b100, 1, 0, 32'h80123456, 0, 0, 0, lat);
      chk("lbu_rdata", core_rdata, 32'h00000080);
      do_txn(1, 32'h102, 32'h0000ABCD, 3'b001, 0, 0, 0, 0, 0, 0, lat);
      chk("sh_be", seen_be1, 4'b1100);
      chk("sh_wdata", seen_wd1, 32'hABCD0000);
      chk("sh_rdata_kept", core_rdata, 32'h00000080);
      do_txn(0, 32'h200, 0, 3'b010, 3, 0, 32'hCAFEF00D, 0, 0, 0, lat);
      chk("wait3_lat", lat, 5);
      chk("wait3_rdata", core_rdata, 32'hCAFEF00D);
      do_txn(0, 32'h300, 0, 3'b010, 9, 0, 32'h55555555, 0, 0, 0, lat);
      chk("tmo_lat", lat, TO + 1);
      chk("tmo_cause", seen_cause, 2'b10);
      do_txn(1, 32'h40, 32'h12345678, 3'b010, 0, 0, 0, 0, 1, 0, lat);
      chk("berr_cause", seen_cause, 2'b11);
      chk("berr_rdata", core_rdata, 32'hCAFEF00D);
      do_txn(0, 32'h1FE, 0, 3'b010, 0, 0, 32'h11220000, 32'h00003344, 0, 0, lat);
`ifdef MISALIGN_SPLIT_EN
      chk("split_lat", lat, 3);
      chk("split_adr1", seen_adr1, 32'h1FC);
      chk("split_be1", seen_be1, 4'b1100);
      chk("split_adr2", seen_adr2, 32'h200);
      chk("split_be2", seen_be2, 4'b0011);
      chk("split_rdata", core_rdata, 32'h33441122);
      do_txn(0, 32'h101, 0, 3'b001, 0, 0, 32'h00BEEF00, 0, 0, 0, lat);
      chk("lh_off1_lat", lat, 2);
      chk("lh_off1_rdata", core_rdata, 32'hFFFFBEEF);
`else
      chk("misal_lat", lat, 1);
      chk("misal_cause", seen_cause, 2'b01);
      chk("misal_novalid", seen_any_valid, 0);
      do_txn(0, 32'h101, 0, 3'b001, 0, 0, 32'h00BEEF00, 0, 0, 0, lat);
      chk("lh_off1_cause", seen_cause, 2'b01);
      chk("lh_off1_rdata", core_rdata, 32'hCAFEF00D);
`endif

      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 5:    f3 = 3'b000;
            1, 6:    f3 = 3'b001;
            2, 7:    f3 = 3'b010;
            3:       f3 = 3'b100;
            4:       f3 = 3'b101;
            8:       f3 = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110;
            default: f3 = 3'($urandom);
         endcase
         adr = $urandom;
         if ($urandom_range(0, 7) == 0) adr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
         w1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 1);
         w2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 1);
         do_txn(1'($urandom), adr, $urandom, f3, w1, w2, $urandom, $urandom,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, lat);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // Reset while a beat is outstanding.
      chk_en = 0;
      core_req = 1; core_we = 0; core_funct3 = 3'b010; core_wdata = 0;
`ifdef MISALIGN_SPLIT_EN
      core_adr = 32'h1FE;
`else
      core_adr = 32'h100;
`endif
      @(posedge clk); #1;
      core_req = 0;
      bus_ready = SPLIT; bus_err = 0; bus_rdata = 32'h01020304;
      @(posedge clk); #1;
      bus_ready = 0;
      #2;
      chk("rst_pre_valid", bus_valid, 1);
      rst = 1;
      #1;
      check_all_zero("midrst");
      @(posedge clk); #1;
      rst = 0;
      exp_rdata = '0;
      set_idle();
      chk_en = 1;
      @(posedge clk); #1;
      do_txn(0, 32'h100, 0, 3'b010, 0, 0, 32'h0BADF00D, 0, 0, 0, lat);
      chk("post_rst_lat", lat, 2);
      chk("post_rst_rdata", core_rdata, 32'h0BADF00D);
      @(posedge clk); #1;
      chk_en = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_lsu_bridge.md
# riscv_lsu_bridge

Parametrised load/store bridge between the multicycle RISC-V core's data-memory port and a valid/ready memory bus. It latches one core access (address, write flag, data, funct3). It then drives byte-enabled, word-aligned bus beats and returns sign- or zero-extended load data with a done/fault pulse. It adds wait-state tolerance, bus-error and timeout reporting, and optional misaligned-access splitting, none of which the current direct memory hookup provides.

## Interface
- ADDR_WIDTH, 32, address width on both the core side and the bus side.
- TIMEOUT, 255, maximum bus wait cycles per beat; 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  1  access request; sampled only in IDLE.
- core_we  in  1  1 = store, 0 = load.
- core_adr  in  ADDR_WIDTH  byte address.
- core_wdata  in  32  store data, right-aligned.
- core_funct3  in  3  RISC-V size/sign code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- core_rdata  out  32  extended load data; holds until the next done.
- core_done  out  1  one-cycle completion pulse.
- core_busy  out  1  high whenever state != IDLE.
- core_fault  out  1  qualifies core_done; the access failed.
- core_fault_cause  out  2  00 none, 01 misaligned/illegal, 10 timeout, 11 bus error.
- bus_valid  out  1  beat request.
- bus_ready  in  1  beat accept.
- bus_we  out  1  beat write.
- bus_adr  out  ADDR_WIDTH  word address; bits [1:0] are always 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted write data.
- bus_rdata  in  32  read data; valid in the cycle bus_valid && bus_ready.
- bus_err  in  1  beat error; valid in the cycle bus_valid && bus_ready.

## Operation
- FSM states and transitions:
  - IDLE -> BEAT1 on core_req when the access is legal.
  - IDLE -> DONE on core_req when the access faults (no bus activity).
  - BEAT1 -> BEAT2 on accept when the access is split.
  - BEAT1 -> DONE on accept otherwise.
  - BEAT2 -> DONE on accept.
  - DONE -> IDLE unconditionally.
- Latching: in IDLE, core_req latches all core inputs. Inputs are don't-care afterwards.
- Size decode from funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes.
  - funct3 = 011, 110 or 111 is illegal: cause 01.
  - funct3 with bit 2 set and a store is illegal: cause 01.
- Offset: off = adr[1:0]. Mask m = size ones.
  - be8 = m << off (8 bits).
  - Beat 1 uses be8[3:0]; beat 2 uses be8[7:4].
  - Split when be8[7:4] != 0.
- Beat addresses: beat 1 = {adr[ADDR_WIDTH-1:2], 2'b00}; beat 2 = beat 1 + 4, wrapping modulo 2^ADDR_WIDTH.
- Write data: w64 = {32'b0, wdata} << (8*off).
  - Beat 1 drives w64[31:0]; beat 2 drives w64[63:32].
- Read data: r64 = {beat2_rdata, beat1_rdata} >> (8*off). Take the low `size` bytes.
  - Sign-extend when funct3[2] = 0; zero-extend when funct3[2] = 1.
- Beat handshake:
  - bus_valid and all bus_* outputs stay stable until bus_ready is sampled high.
  - The beat completes in that cycle.
- Bus error: bus_err on any accepted beat aborts the access with cause 11.
  - A pending beat 2 is skipped.
  - Beat-1 store lanes are already committed, and no rollback is done.
- Timeout: a per-beat counter increments each cycle bus_valid && !bus_ready.
  - When the counter reaches TIMEOUT, bus_valid drops and the access finishes as cause 10.
  - The counter clears on every new beat.
- Faulted loads leave core_rdata unchanged. Stores never modify core_rdata.
- Reset values: every output is 0, state is IDLE, and the counter is 0.
- Reset mid-operation abandons the beat immediately. The bus slave must tolerate a dropped bus_valid.

## Timing
- core_req accepted at edge N: bus_valid is high from cycle N+1.
- Zero-wait single-beat access: accept in N+1, core_done in N+2.
- Zero-wait split access: beat 2 valid in N+2, core_done in N+3.
- Fault detected in IDLE: core_done and core_fault in N+1.
- Each bus wait cycle adds 1 cycle of latency.
- core_done, core_fault and core_fault_cause are registered and are high only in DONE. core_fault_cause is 00 otherwise.
- core_req in DONE or in any busy state is ignored. A request is accepted again at the earliest one cycle after core_done.
- bus_valid is low in DONE, so there is at least one idle cycle between accesses.

## Configuration
- MISALIGN_SPLIT_EN defined: word-crossing accesses (lh at off 3; lw at off 1, 2 or 3) run as two beats.
- MISALIGN_SPLIT_EN undefined: any access with adr not a multiple of size faults with cause 01 and no bus activity. In this build, BEAT2 and the 64-bit shift upper half are not synthesised.
- Non-crossing misaligned halfword (lh at off 1): a single beat when the macro is defined; a fault when it is undefined.

## Test plan
- lw, adr 0x100, bus_rdata 0xDEADBEEF, ready in the first cycle -> bus_be 1111, bus_adr 0x100, core_rdata 0xDEADBEEF, core_done 2 cycles after req.
- lb adr 0x103 with bus_rdata 0x80xxxxxx -> core_rdata 0xFFFFFF80. lbu at the same address -> 0x00000080. sh 0xABCD at 0x102 -> bus_be 1100, bus_wdata 0xABCD0000.
- bus_ready held low for 3 cycles, then high -> bus_valid and bus_adr stable throughout, core_done 5 cycles after req. With TIMEOUT=2 and ready never high -> cause 10 with core_fault.
- bus_err on a sw at 0x40 -> core_fault with cause 11, core_rdata unchanged from the previous load.
- lw at 0x1FE, beat 1 rdata 0x1122xxxx, beat 2 rdata 0xxxxx3344:
  - MISALIGN_SPLIT_EN defined -> beats at 0x1FC (be 1100) and 0x200 (be 0011), core_rdata 0x33441122.
  - MISALIGN_SPLIT_EN undefined -> cause 01 in N+1, bus_valid never high.
- rst asserted while bus_valid is high in BEAT2 -> all outputs 0 immediately. A new lw after reset completes normally.
